// File: rtl/sdram_refresh_sequencer_if.sv
// Command-bus and refresh-handshake bundle between the refresh sequencer
// (master) and the Wishbone SDRAM datapath / pad mux (slave).
interface sdram_refresh_sequencer_if #(
   parameter int ADDR_BITS = 13
);
   logic                 init_done_o;
   logic                 ref_req_o;
   logic                 ref_gnt_i;
   logic                 own_bus_o;
   logic                 ref_ovf_o;
   logic                 cke_o;
   logic                 cs_n_o;
   logic                 ras_n_o;
   logic                 cas_n_o;
   logic                 we_n_o;
   logic [ADDR_BITS-1:0] addr_o;
   logic [1:0]           ba_o;

   modport master (
      output init_done_o, ref_req_o, own_bus_o, ref_ovf_o, cke_o,
             cs_n_o, ras_n_o, cas_n_o, we_n_o, addr_o, ba_o,
      input  ref_gnt_i
   );

   modport slave (
      input  init_done_o, ref_req_o, own_bus_o, ref_ovf_o, cke_o,
             cs_n_o, ras_n_o, cas_n_o, we_n_o, addr_o, ba_o,
      output ref_gnt_i
   );
endinterface

// File: rtl/sdram_refresh_sequencer.sv
// SDRAM power-up init and periodic auto-refresh sequencer. Owns the command
// bus during init and refresh service; otherwise the datapath drives the pads.
// Every command is a single-cycle pulse; all other owned cycles are NOP.
module sdram_refresh_sequencer #(
   parameter int                   ADDR_BITS        = 13,
   parameter int                   INIT_CYCLES      = 10000,
   parameter int                   INIT_REFRESHES   = 2,
   parameter int                   T_RP             = 2,
   parameter int                   T_RFC            = 7,
   parameter int                   T_MRD            = 2,
   parameter int                   REFRESH_INTERVAL = 390,
   parameter logic [ADDR_BITS-1:0] MODE_REG         = 'h031
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   sdram_refresh_sequencer_if.master  bus
);
   // one counter serves the init NOP wait and every post-command wait
   localparam int CW = $clog2(INIT_CYCLES + T_RP + T_RFC + T_MRD + 2);
   localparam int IW = $clog2(INIT_REFRESHES + 2);
   localparam int TW = $clog2(REFRESH_INTERVAL + 1);

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP = 4'b1111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;
   localparam logic [3:0] CMD_MRS = 4'b0000;
   localparam logic [ADDR_BITS-1:0] A10 = ADDR_BITS'(1) << 10;

   typedef enum logic [2:0] {
      RST_WAIT, I_PRE, I_REF, I_MRS, IDLE, REQ, R_PRE, R_AR
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [IW-1:0]        r_icnt;
   logic [TW-1:0]        r_tmr;
   logic [2:0]           r_pend;
   logic                 r_cke;
   logic [3:0]           r_cmd;
   logic [ADDR_BITS-1:0] r_addr;
   logic [1:0]           r_ba;
   logic                 r_init_done;
   logic                 r_req;
   logic                 r_own;
   logic                 r_ovf;

   logic                 w_wrap;
   logic                 w_ar_go;

   // timer wrap adds a pending refresh; an issued refresh AR consumes one
   assign w_wrap  = r_init_done && (r_tmr == TW'(REFRESH_INTERVAL - 1));
   assign w_ar_go = ((r_state == R_PRE) && (r_cnt == CW'(T_RP))) ||
                    ((r_state == R_AR) && (r_cnt == CW'(T_RFC)) && (r_pend != 3'd0));

   // init + refresh sequencer; all pad-facing outputs registered here
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state     <= RST_WAIT;
         r_cnt       <= '0;
         r_icnt      <= '0;
         r_cke       <= 1'b0;
         r_cmd       <= CMD_NOP;
         r_addr      <= '0;
         r_ba        <= '0;
         r_init_done <= 1'b0;
         r_req       <= 1'b0;
         r_own       <= 1'b1;
      end else begin
         r_cmd  <= CMD_NOP;
         r_addr <= '0;
         r_ba   <= '0;
         r_cnt  <= r_cnt + 1'b1;
         case (r_state)
            RST_WAIT: begin
               r_cke <= 1'b1;
               if (r_cnt == CW'(INIT_CYCLES)) begin
                  r_cmd   <= CMD_PRE;
                  r_addr  <= A10;
                  r_cnt   <= '0;
                  r_state <= I_PRE;
               end
            end
            I_PRE: if (r_cnt == CW'(T_RP)) begin
               r_cmd   <= CMD_AR;
               r_cnt   <= '0;
               r_icnt  <= IW'(1);
               r_state <= I_REF;
            end
            I_REF: if (r_cnt == CW'(T_RFC)) begin
               r_cnt <= '0;
               if (r_icnt == IW'(INIT_REFRESHES)) begin
                  r_cmd   <= CMD_MRS;
                  r_addr  <= MODE_REG;
                  r_state <= I_MRS;
               end else begin
                  r_cmd  <= CMD_AR;
                  r_icnt <= r_icnt + 1'b1;
               end
            end
            I_MRS: if (r_cnt == CW'(T_MRD)) begin
               r_init_done <= 1'b1;
               r_own       <= 1'b0;
               r_state     <= IDLE;
            end
            IDLE: begin
               r_cnt <= '0;
               if (r_pend != 3'd0) begin
                  r_req   <= 1'b1;
                  r_state <= REQ;
               end
            end
            REQ: begin
               r_cnt <= '0;
               if (bus.ref_gnt_i) begin
                  r_req   <= 1'b0;
                  r_own   <= 1'b1;
                  r_cmd   <= CMD_PRE;
                  r_addr  <= A10;
                  r_state <= R_PRE;
               end
            end
            R_PRE: if (w_ar_go) begin
               r_cmd   <= CMD_AR;
               r_cnt   <= '0;
               r_state <= R_AR;
            end
            R_AR: if (r_cnt == CW'(T_RFC)) begin
               r_cnt <= '0;
               // drain all pending refreshes without giving the bus back
               if (w_ar_go) begin
                  r_cmd <= CMD_AR;
               end else begin
                  r_own   <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= RST_WAIT;
         endcase
      end
   end

   // refresh interval timer and saturating pending-refresh counter
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_tmr  <= '0;
         r_pend <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (r_init_done) begin
            r_tmr <= w_wrap ? '0 : r_tmr + 1'b1;
         end
         case ({w_wrap, w_ar_go})
            2'b10: begin
               if (r_pend == 3'd7) r_ovf  <= 1'b1;
               else                r_pend <= r_pend + 1'b1;
            end
            2'b01:   r_pend <= r_pend - 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.init_done_o = r_init_done;
   assign bus.ref_req_o   = r_req;
   assign bus.own_bus_o   = r_own;
   assign bus.ref_ovf_o   = r_ovf;
   assign bus.cke_o       = r_cke;
   assign bus.cs_n_o      = r_cmd[3];
   assign bus.ras_n_o     = r_cmd[2];
   assign bus.cas_n_o     = r_cmd[1];
   assign bus.we_n_o      = r_cmd[0];
   assign bus.addr_o      = r_addr;
   assign bus.ba_o        = r_ba;
endmodule
